mystic_alu_arbiter: RTL
=======================

// Module: mystic_alu_arbiter
// PURPOSE
//   Shares one multi-cycle mystic ALU between NUM_REQ requesters (decode, branch, AGU, ...).
//   - Round-robin grant; one operation in flight at a time.
//   - Holds the ALU's opcode and operands stable until the ALU reports ready.
//   - Screens illegal opcodes and bounds each ALU wait with a timeout.
//   - Returns the result, with a one-hot response strobe, to the requester that issued it.
// PARAMETERS
//   NUM_REQ   2    number of requesters (>=2)
//   TIMEOUT   15   max cycles in WAIT without alu_ready_i before error response (>=4)
// PORTS
//   clk_i               in   1            single clock, rising edge
//   rst_i               in   1            asynchronous, active-high reset
//   req_valid_i         in   NUM_REQ      per-requester op request; held until accepted
//   req_opcode_i        in   NUM_REQ*6    packed opcodes, requester i at [6i+5:6i]
//   req_srcA_i          in   NUM_REQ*64   packed operand A
//   req_srcB_i          in   NUM_REQ*64   packed operand B
//   req_ready_o         out  NUM_REQ      one-hot accept; transfer when valid&ready
//   rsp_valid_o         out  NUM_REQ      one-hot, 1-cycle response strobe; no back-pressure
//   rsp_result_o        out  64           result, valid with rsp_valid_o
//   rsp_error_o         out  1            1 = illegal opcode or timeout, valid with rsp_valid_o
//   alu_opcode_o        out  6            to ALU, stable IDLE-exit..RESP
//   alu_opcode_valid_o  out  1            to ALU, 1-cycle start pulse
//   alu_srcA_o          out  64           to ALU, held stable through WAIT
//   alu_srcB_o          out  64           to ALU, held stable through WAIT
//   alu_result_i        in   64           from ALU
//   alu_ready_i         in   1            from ALU, 1-cycle done pulse
// BEHAVIOUR
//   Reset
//     - All outputs 0; FSM=IDLE; RR pointer last=NUM_REQ-1, so requester 0 has top priority.
//     - Reset mid-operation aborts silently: no response is issued.
//     - The ALU is reset by the same system reset (top level inverts it for rstn_i).
//   FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE
//     - req_ready_o = combinational one-hot grant over req_valid_i.
//     - Priority starts at last+1 and wraps modulo NUM_REQ.
//     - On accept: register opcode/srcA/srcB/requester id; last <= id.
//     - Legal opcode (0..7) -> ISSUE. Illegal (>7) -> RESP with error=1, result=0; ALU untouched.
//   ISSUE
//     - alu_opcode_valid_o=1 for exactly one cycle -> WAIT; timeout counter cleared.
//   WAIT
//     - Operands and opcode held. On alu_ready_i: capture alu_result_i, error=0 -> RESP.
//     - Counter reaches TIMEOUT with no ready -> RESP, error=1, result=0.
//   RESP
//     - rsp_valid_o[id]=1, result and error registered, for one cycle -> IDLE.
//   req_ready_o is 0 in every state except IDLE.
//   Latency with the standard ALU (accept in cycle T):
//     - ALU EXECUTE in T+2, alu_ready_i in T+3, rsp_valid_o in T+4.
//     - Next accept no earlier than T+5.
//   Illegal opcode: rsp_valid_o in T+1.
//   Boundary cases
//     - Simultaneous requests: exactly one grant, per RR.
//     - Losing requesters keep valid asserted; a persistently requesting loser is served
//       within NUM_REQ grants.
//     - alu_ready_i outside WAIT is ignored.
//     - alu_ready_i in the same cycle the counter hits TIMEOUT: ready wins, error=0.
//     - req_valid_i dropped before accept: no effect.
//     - Opcode changing while unaccepted: the value sampled at accept is used.
// STRUCTURE
//   mystic_pkg
//     - XLEN=64, ALU_OP_W=6.
//     - ALU opcode localparams: ADD 0, AND 1, OR 2, SLL 3, SRA 4, SRL 5, XOR 6, SUB 7;
//       ALU_OP_MAX=7.
//     - Arbiter state encodings.
//   Sub-module mystic_rr_arbiter #(N)
//     - Inputs: req, last_id. Outputs: one-hot grant, grant_id. Pure combinational.
//   Top: FSM, operand/ID registers, timeout counter, response registers.
// TESTING (bench instantiates mystic_alu behind the arbiter, NUM_REQ=2)
//   1. Req0 ADD A=5,B=7, accepted in T
//      -> rsp_valid_o=2'b01 in T+4, result=12, error=0; alu_opcode_valid_o high only in T+1.
//   2. Req0 SUB 3-5 and req1 XOR FF^0F both valid out of reset
//      -> req0 served first (result 64'hFFFF_FFFF_FFFF_FFFE), then req1 (result F0).
//   3. Both valid continuously for 4 ops
//      -> grants alternate 0,1,0,1; no starvation.
//   4. Req1 opcode 6'd9
//      -> rsp_valid_o=2'b10 one cycle after accept, error=1, result=0; alu_opcode_valid_o stays 0.
//   5. Stub ALU never asserts ready, req0 AND
//      -> rsp_valid_o=2'b01 with error=1 after TIMEOUT WAIT cycles; next request still serviced.
//   6. Assert rst_i while in WAIT
//      -> outputs 0 immediately, no rsp_valid_o; after release req0 ADD 1+1 returns 2.

Source files
------------

// File: rtl/mystic_pkg.sv
// Shared types and constants for the mystic ALU and its requester arbiter.
package mystic_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 6'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 6'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 6'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL = 6'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA = 6'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL = 6'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 6'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 6'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 6'd7;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Operation payload held toward the ALU while it is in flight.
    typedef struct packed {
        logic [ALU_OP_W-1:0] opcode;
        logic [XLEN-1:0]     src_a;
        logic [XLEN-1:0]     src_b;
    } alu_req_t;

    // Opcodes above ALU_OP_MAX are answered with an error and never reach the ALU.
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        return (op <= ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/mystic_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_id_i wins.
module mystic_rr_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_id_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] grant_id_o
);

    logic            found_c;
    logic [ID_W-1:0] idx_c;

    // Scan from last_id_i+1 with wrap; the first asserted request is granted.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found_c    = 1'b0;
        idx_c      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx_c = ID_W'((32'(last_id_i) + off) % N);
            if (!found_c && req_i[idx_c]) begin
                found_c        = 1'b1;
                grant_o[idx_c] = 1'b1;
                grant_id_o     = idx_c;
            end
        end
    end

endmodule

// File: rtl/mystic_alu_arbiter.sv
// Shares one multi-cycle mystic ALU between NUM_REQ requesters, one op in flight.
module mystic_alu_arbiter
    import mystic_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_opcode_i,
    input  logic [NUM_REQ*XLEN-1:0]     req_srcA_i,
    input  logic [NUM_REQ*XLEN-1:0]     req_srcB_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [XLEN-1:0]             rsp_result_o,
    output logic                        rsp_error_o,
    output logic [ALU_OP_W-1:0]         alu_opcode_o,
    output logic                        alu_opcode_valid_o,
    output logic [XLEN-1:0]             alu_srcA_o,
    output logic [XLEN-1:0]             alu_srcB_o,
    input  logic [XLEN-1:0]             alu_result_i,
    input  logic                        alu_ready_i
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    alu_req_t             op_q, op_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 alu_valid_q, alu_valid_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]      rsp_result_q, rsp_result_d;
    logic                 rsp_error_q, rsp_error_d;

    logic [NUM_REQ-1:0]   grant_c;
    logic [ID_W-1:0]      grant_id_c;
    logic                 accept_c;
    alu_req_t             sel_req_c;

    mystic_rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req_i      (req_valid_i),
        .last_id_i  (last_q),
        .grant_o    (grant_c),
        .grant_id_o (grant_id_c)
    );

    // Accept is only offered in IDLE and is suppressed while reset is asserted.
    assign req_ready_o = ((state_q == ARB_IDLE) && !rst_i) ? grant_c : '0;
    assign accept_c    = (state_q == ARB_IDLE) && (|grant_c);

    // Route the granted requester's opcode and operands.
    always_comb begin
        sel_req_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_req_c.opcode = req_opcode_i[i*ALU_OP_W +: ALU_OP_W];
                sel_req_c.src_a  = req_srcA_i[i*XLEN +: XLEN];
                sel_req_c.src_b  = req_srcB_i[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state logic: grant, issue pulse, bounded wait, one-cycle response.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        alu_valid_d  = 1'b0;
        rsp_valid_d  = '0;
        rsp_result_d = '0;
        rsp_error_d  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (accept_c) begin
                    id_d   = grant_id_c;
                    last_d = grant_id_c;
                    if (alu_op_legal(sel_req_c.opcode)) begin
                        op_d        = sel_req_c;
                        alu_valid_d = 1'b1;
                        state_d     = ARB_ISSUE;
                    end else begin
                        rsp_valid_d = NUM_REQ'(1) << grant_id_c;
                        rsp_error_d = 1'b1;
                        state_d     = ARB_RESP;
                    end
                end
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (alu_ready_i) begin
                    rsp_valid_d  = NUM_REQ'(1) << id_q;
                    rsp_result_d = alu_result_i;
                    state_d      = ARB_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d = NUM_REQ'(1) << id_q;
                    rsp_error_d = 1'b1;
                    state_d     = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset aborts any operation silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            op_q         <= '0;
            id_q         <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            alu_valid_q  <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            alu_valid_q  <= alu_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign alu_opcode_o       = op_q.opcode;
    assign alu_srcA_o         = op_q.src_a;
    assign alu_srcB_o         = op_q.src_b;
    assign alu_opcode_valid_o = alu_valid_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_result_o       = rsp_result_q;
    assign rsp_error_o        = rsp_error_q;

endmodule
